// File: rtl/uart_rx_cfg_if.sv
// Register bus and serial input bundle for uart_rx_cfg.
// The master side drives the register strobes and the pin, and the slave side returns read data.
interface uart_rx_cfg_if;
   logic       wren;
   logic       rden;
   logic [2:0] addr;
   logic [7:0] din;
   logic [9:0] dout;
   logic       rxin;

   modport master (output wren, output rden, output addr, output din, output rxin, input dout);
   modport slave  (input wren, input rden, input addr, input din, input rxin, output dout);
endinterface

// File: rtl/uart_rx_cfg.sv
// 16x oversampled UART receiver: 5-8 data bits, none/even/odd parity, FIFO with threshold, break and overrun.
// Optional macro UART_RX_TIMEOUT_EN enables the idle-receive TIMEOUT flag (STATUS bit 5).
module uart_rx_cfg #(
   parameter int FIFO_DEPTH  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          reset,
   uart_rx_cfg_if.slave  bus
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRKWAIT
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   rxs;
   logic [7:0]             period_q, period_d, period_lat_q, period_lat_d;
   logic [7:0]             cfg_q, cfg_d;
   logic [1:0]             nbits_lat_q, nbits_lat_d, par_lat_q, par_lat_d;
   logic                   rxen_q, rxen_d;
   logic [8:0]             tick_cnt_q, tick_cnt_d, tick_lim;
   logic [7:0]             period_use;
   logic                   tick;
   state_t                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [2:0]             bit_q, bit_d;
   logic [7:0]             shift_q, shift_d;
   logic                   perr_q, perr_d, pbit_q, pbit_d;
   logic [AW:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level;
   logic [9:0]             mem_q [FIFO_DEPTH];
   logic                   ovr_q, ovr_d, brk_q, brk_d;
   logic                   rd5_prev_q, rd5_prev_d;
   logic [9:0]             dout_q, dout_d, rd_sel;
   logic                   push, push_ok, pop, brk_set, ovr_set;
   logic [9:0]             push_data;
   logic                   empty, full, thresh, par_en, last_bit, rd5;
   logic                   wr_period, wr_cfg, wr_ctrl, timeout_flag;
   logic [7:0]             status;

   assign rxs       = sync_q[SYNC_STAGES-1];
   assign wr_period = bus.wren && (bus.addr == 3'd4);
   assign wr_cfg    = bus.wren && (bus.addr == 3'd6);
   assign wr_ctrl   = bus.wren && (bus.addr == 3'd7);
   assign rd5       = bus.rden && (bus.addr == 3'd5);
   assign bus.dout  = dout_q;

   // Outside a frame the live PERIOD drives the tick; inside, the value latched at START.
   assign period_use = (state_q == S_IDLE) ? period_q : period_lat_q;
   assign tick_lim   = {period_use, 1'b1};

   always_comb begin
      tick       = 1'b0;
      tick_cnt_d = tick_cnt_q + 9'd1;
      if (wr_period && (state_q == S_IDLE)) begin
         tick_cnt_d = '0;
      end else if (tick_cnt_q >= tick_lim) begin
         tick       = 1'b1;
         tick_cnt_d = '0;
      end
   end

   assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.rxin};

   assign period_d = wr_period ? bus.din : period_q;
   assign cfg_d    = wr_cfg ? bus.din : cfg_q;
   assign rxen_d   = wr_ctrl ? bus.din[0] : rxen_q;

   assign par_en   = (par_lat_q == 2'b01) || (par_lat_q == 2'b10);
   assign last_bit = (bit_q == (3'd4 + {1'b0, nbits_lat_q}));

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      bit_d        = bit_q;
      shift_d      = shift_q;
      perr_d       = perr_q;
      pbit_d       = pbit_q;
      nbits_lat_d  = nbits_lat_q;
      par_lat_d    = par_lat_q;
      period_lat_d = period_lat_q;
      push         = 1'b0;
      push_data    = {perr_q, ~rxs, shift_q};
      brk_set      = 1'b0;
      if (!rxen_q) begin
         state_d = S_IDLE;
      end else if (tick) begin
         case (state_q)
            S_IDLE: begin
               if (!rxs) begin
                  state_d      = S_START;
                  cnt_d        = '0;
                  nbits_lat_d  = cfg_q[1:0];
                  par_lat_d    = cfg_q[3:2];
                  period_lat_d = period_q;
               end
            end
            S_START: begin
               if (cnt_q == 4'd7) begin
                  cnt_d = '0;
                  if (rxs) begin
                     state_d = S_IDLE;
                  end else begin
                     state_d = S_DATA;
                     bit_d   = '0;
                     shift_d = '0;
                     perr_d  = 1'b0;
                     pbit_d  = 1'b0;
                  end
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            S_DATA: begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd15) begin
                  shift_d[bit_q] = rxs;
                  if (last_bit) state_d = par_en ? S_PARITY : S_STOP;
                  else          bit_d   = bit_q + 3'd1;
               end
            end
            S_PARITY: begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd15) begin
                  pbit_d  = rxs;
                  perr_d  = (^shift_q) ^ rxs ^ (par_lat_q == 2'b10);
                  state_d = S_STOP;
               end
            end
            S_STOP: begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd15) begin
                  push = 1'b1;
                  // An all-zero character including parity and stop is a line break.
                  if (!rxs && (shift_q == 8'd0) && !pbit_q) begin
                     brk_set = 1'b1;
                     state_d = S_BRKWAIT;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end
            S_BRKWAIT: begin
               if (rxs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign level   = wr_ptr_q - rd_ptr_q;
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (level == (AW+1)'(FIFO_DEPTH));
   assign pop     = rd5 && !rd5_prev_q && !empty;
   assign push_ok = push && (!full || pop);
   assign ovr_set = push && full && !pop;
   assign thresh  = (cfg_q[7:4] != 4'd0) && (32'(level) >= 32'(cfg_q[7:4]));
   assign rd5_prev_d = rd5;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovr_d    = ovr_q | ovr_set;
      brk_d    = brk_q | brk_set;
      if (!rxen_q) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         ovr_d    = 1'b0;
         brk_d    = 1'b0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

`ifdef UART_RX_TIMEOUT_EN
   logic [9:0] to_cnt_q, to_cnt_d;
   logic       to_q, to_d, start_evt, to_clr;

   assign start_evt = rxen_q && tick && (state_q == S_IDLE) && !rxs;
   assign to_clr    = !rxen_q || pop || start_evt;

   // 640 ticks is four 10-bit characters of silence with data still waiting.
   always_comb begin
      to_cnt_d = to_cnt_q;
      to_d     = to_q;
      if (to_clr || empty) begin
         to_cnt_d = '0;
         if (to_clr) to_d = 1'b0;
      end else if (tick && !to_q) begin
         if (to_cnt_q == 10'd639) begin
            to_d     = 1'b1;
            to_cnt_d = '0;
         end else begin
            to_cnt_d = to_cnt_q + 10'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_cnt_q <= '0;
         to_q     <= 1'b0;
      end else begin
         to_cnt_q <= to_cnt_d;
         to_q     <= to_d;
      end
   end

   assign timeout_flag = to_q;
`else
   assign timeout_flag = 1'b0;
`endif

   assign status = {2'b00, timeout_flag, brk_q, thresh, ovr_q, !empty, rxen_q};

   always_comb begin
      rd_sel = '0;
      case (bus.addr)
         3'd4:    rd_sel = {2'b00, period_q};
         3'd5:    rd_sel = empty ? 10'd0 : mem_q[rd_ptr_q[AW-1:0]];
         3'd6:    rd_sel = {2'b00, cfg_q};
         3'd7:    rd_sel = {2'b00, status};
         default: rd_sel = '0;
      endcase
      dout_d = bus.rden ? rd_sel : 10'd0;
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q       <= '1;
         period_q     <= '0;
         period_lat_q <= '0;
         cfg_q        <= 8'h03;
         nbits_lat_q  <= 2'b11;
         par_lat_q    <= 2'b00;
         rxen_q       <= 1'b0;
         tick_cnt_q   <= '0;
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         perr_q       <= 1'b0;
         pbit_q       <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         ovr_q        <= 1'b0;
         brk_q        <= 1'b0;
         rd5_prev_q   <= 1'b0;
         dout_q       <= '0;
      end else begin
         sync_q       <= sync_d;
         period_q     <= period_d;
         period_lat_q <= period_lat_d;
         cfg_q        <= cfg_d;
         nbits_lat_q  <= nbits_lat_d;
         par_lat_q    <= par_lat_d;
         rxen_q       <= rxen_d;
         tick_cnt_q   <= tick_cnt_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
         perr_q       <= perr_d;
         pbit_q       <= pbit_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         ovr_q        <= ovr_d;
         brk_q        <= brk_d;
         rd5_prev_q   <= rd5_prev_d;
         dout_q       <= dout_d;
      end
   end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: serial characters are driven on rxin and expected FIFO words
// are queued, then popped and compared as the register interface reads them back.
module tb_uart_rx_cfg;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_fail = 0;
   int   bit_clks = 32;
   logic [9:0] exp_q[$];

   uart_rx_cfg_if bus ();

   uart_rx_cfg #(.FIFO_DEPTH(16), .SYNC_STAGES(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic reg_write(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      bus.wren = 1'b1;
      bus.addr = a;
      bus.din  = d;
      @(negedge clk);
      bus.wren = 1'b0;
   endtask

   task automatic reg_read(input logic [2:0] a, output logic [9:0] d);
      @(negedge clk);
      bus.rden = 1'b1;
      bus.addr = a;
      @(posedge clk);
      #1 d = bus.dout;
      @(negedge clk);
      bus.rden = 1'b0;
   endtask

   task automatic check_reg(input string tag, input logic [2:0] a, input logic [9:0] exp);
      logic [9:0] d;
      reg_read(a, d);
      check(tag, d, exp);
   endtask

   task automatic check_fifo(input string tag);
      logic [9:0] d;
      logic [9:0] e;
      reg_read(3'd5, d);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'd0;
      check(tag, d, e);
   endtask

   // pm: 00 none, 01 even, 10 odd. Expected word is queued unless the character will be dropped.
   task automatic send_char(input logic [7:0] d, input int nb, input logic [1:0] pm,
                            input bit bad_par, input logic stop_v, input bit queue_it);
      logic p;
      logic pbit;
      logic [7:0] m;
      p = 1'b0;
      m = 8'd0;
      @(negedge clk);
      bus.rxin = 1'b0;
      idle(bit_clks);
      for (int i = 0; i < nb; i++) begin
         bus.rxin = d[i];
         p = p ^ d[i];
         m[i] = d[i];
         idle(bit_clks);
      end
      if (pm == 2'b01 || pm == 2'b10) begin
         pbit = (pm == 2'b10) ? ~p : p;
         if (bad_par) pbit = ~pbit;
         bus.rxin = pbit;
         idle(bit_clks);
      end
      bus.rxin = stop_v;
      idle(bit_clks);
      bus.rxin = 1'b1;
      if (!stop_v) idle(bit_clks);
      if (queue_it) exp_q.push_back({bad_par && (pm == 2'b01 || pm == 2'b10), ~stop_v, m});
   endtask

   initial begin
      bus.wren = 1'b0;
      bus.rden = 1'b0;
      bus.addr = 3'd0;
      bus.din  = 8'd0;
      bus.rxin = 1'b1;
      idle(4);
      reset = 1'b0;
      idle(2);

      check("reset_dout", bus.dout, 10'h000);
      check_reg("reset_status", 3'd7, 10'h000);
      check_reg("reset_config", 3'd6, 10'h003);
      check_reg("reset_period", 3'd4, 10'h000);
      check_fifo("reset_fifo_empty");

      // 8N1 at PERIOD 0x0C
      reg_write(3'd4, 8'h0C);
      check_reg("period_rb", 3'd4, 10'h00C);
      reg_write(3'd7, 8'h01);
      bit_clks = 32 * 13;
      send_char(8'h39, 8, 2'b00, 1'b0, 1'b1, 1'b1);
      check_reg("status_rdy", 3'd7, 10'h003);
      check_fifo("rx_0x39");
      check_reg("status_empty", 3'd7, 10'h001);

      reg_write(3'd4, 8'h00);
      bit_clks = 32;

      reg_write(3'd6, 8'h07);
      send_char(8'hD3, 8, 2'b01, 1'b1, 1'b1, 1'b1);
      check_fifo("even_bad_par");
      send_char(8'hD3, 8, 2'b01, 1'b0, 1'b1, 1'b1);
      check_fifo("even_good_par");
      reg_write(3'd6, 8'h0B);
      send_char(8'h5A, 8, 2'b10, 1'b0, 1'b1, 1'b1);
      check_fifo("odd_good_par");
      send_char(8'h5A, 8, 2'b10, 1'b1, 1'b1, 1'b1);
      check_fifo("odd_bad_par");

      reg_write(3'd6, 8'h02);
      send_char(8'h55, 7, 2'b00, 1'b0, 1'b1, 1'b1);
      check_fifo("7n1_0x55");
      reg_write(3'd6, 8'h00);
      send_char(8'h1F, 5, 2'b00, 1'b0, 1'b1, 1'b1);
      check_fifo("5n1_0x1f");
      reg_write(3'd6, 8'h03);

      // start-bit glitch
      @(negedge clk);
      bus.rxin = 1'b0;
      idle(4);
      bus.rxin = 1'b1;
      idle(400);
      check_reg("glitch_status", 3'd7, 10'h001);
      check_fifo("glitch_fifo_empty");

      send_char(8'h55, 8, 2'b00, 1'b0, 1'b0, 1'b1);
      check_fifo("ferr_0x55");

      // line break for two character times
      @(negedge clk);
      bus.rxin = 1'b0;
      idle(20 * bit_clks);
      bus.rxin = 1'b1;
      idle(10 * bit_clks);
      exp_q.push_back(10'h100);
      check_reg("break_status", 3'd7, 10'h013);
      check_fifo("break_entry");
      check_reg("break_sticky", 3'd7, 10'h011);
      reg_write(3'd7, 8'h00);
      check_reg("rxen_off_clear", 3'd7, 10'h000);
      reg_write(3'd7, 8'h01);

      send_char(8'h41, 8, 2'b00, 1'b0, 1'b1, 1'b1);
      check_reg("to_before", 3'd7, 10'h003);
      idle(1400);
`ifdef UART_RX_TIMEOUT_EN
      check_reg("to_after", 3'd7, 10'h023);
`else
      check_reg("to_after", 3'd7, 10'h003);
`endif
      check_fifo("to_entry");
      check_reg("to_cleared", 3'd7, 10'h001);

      // fill, threshold and overrun
      reg_write(3'd6, 8'h83);
      for (int i = 0; i < 7; i++) send_char(8'h30 + 8'(i), 8, 2'b00, 1'b0, 1'b1, 1'b1);
      check_reg("below_thr", 3'd7, 10'h003);
      for (int i = 7; i < 16; i++) send_char(8'h30 + 8'(i), 8, 2'b00, 1'b0, 1'b1, 1'b1);
      check_reg("full_no_ovr", 3'd7, 10'h00B);
      send_char(8'h40, 8, 2'b00, 1'b0, 1'b1, 1'b0);
      check_reg("overrun", 3'd7, 10'h00F);
      for (int i = 0; i < 16; i++) check_fifo($sformatf("drain_%0d", i));
      check_reg("drained", 3'd7, 10'h005);
      check_fifo("drained_empty");
      reg_write(3'd7, 8'h00);
      check_reg("ovr_cleared", 3'd7, 10'h000);
      reg_write(3'd7, 8'h01);
      send_char(8'hA7, 8, 2'b00, 1'b0, 1'b1, 1'b1);
      check_fifo("after_reen");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
